sprdma: RTL and testbench
=========================

// Module: sprdma
//
// PURPOSE
// - Sprite (OAM) DMA engine: the bus *initiator* paired with the CPU memory controller (cpumc).
// - A CPU write to the trigger address (0x4014) starts a transfer.
//   The block then copies one 256-byte CPU page {page,8'h00}..{page,8'hFF} to the PPU OAM data port (0x2004).
// - While active, it owns the memory bus: top level muxes mem_* into cpumc and halts the CPU.
//
// PARAMETERS
// TRIGGER_ADDR  16'h4014  CPU write address that starts a transfer
// DST_ADDR      16'h2004  destination address written once per byte
// XFER_LEN      256       bytes per transfer (power of 2, max 256)
//
// PORTS
// clk          in   1   50MHz system clock
// rst          in   1   synchronous, active-high reset
// cpu_addr     in   16  CPU bus address (snooped)
// cpu_wr       in   1   CPU write strobe
// cpu_din      in   8   CPU write data (page number on trigger)
// mem_rd_data  in   8   cpumc read data (1-cycle synchronous read latency)
// mem_addr     out  16  bus address driven to cpumc while active
// mem_wr       out  1   bus write enable while active
// mem_wr_data  out  8   bus write data
// active       out  1   1 = DMA owns bus, CPU must be halted
//
// BEHAVIOUR
// - Clock and reset:
//   - One clock; reset is synchronous and active-high.
//   - On rst: state=IDLE, page=0, idx=0, active=0, mem_wr=0, mem_addr=0, mem_wr_data=0.
//   - rst mid-transfer aborts the transfer: next cycle is IDLE with active=0 and no further writes.
// - States: IDLE, START, READ, WRITE.
// - IDLE:
//   - Trigger condition: cpu_wr=1 and cpu_addr==TRIGGER_ADDR, sampled at the clock edge.
//   - On trigger: page<=cpu_din, idx<=0, go to START.
//   - Triggers outside IDLE are ignored.
//   - Reads of TRIGGER_ADDR and writes to other addresses never trigger.
// - START:
//   - One dead cycle; lets the CPU write cycle retire.
//   - mem_wr=0, mem_addr=0. Next state: READ.
// - READ:
//   - mem_addr={page,idx}, mem_wr=0. Next state: WRITE.
// - WRITE:
//   - mem_addr=DST_ADDR, mem_wr=1, mem_wr_data=mem_rd_data (combinational).
//   - mem_rd_data holds the byte addressed in the preceding READ cycle.
//   - If idx==XFER_LEN-1: go to IDLE. Otherwise idx<=idx+1 and go to READ.
// - idx is 8 bits and never wraps within a transfer. The source page is fixed per transfer.
// - active=1 in START/READ/WRITE, 0 in IDLE.
//   - Full transfer: active is high for exactly 1+2*XFER_LEN cycles (513 by default).
//   - Exactly XFER_LEN write pulses, one cycle each.
// - Outside WRITE: mem_wr=0 and mem_wr_data=0. In IDLE: mem_addr=0.
// - Back-to-back: a trigger sampled in the first IDLE cycle after the final WRITE is accepted.
// - Page 0x20-0x3F: the block still issues the source reads; read side effects are the bus owner's concern.
//
// TESTING
// 1. Preload RAM 0x0200-0x02FF with (i^8'h5A).
//    CPU writes 0x02 to 0x4014 -> 256 writes to 0x2004 with data 5A,5B,58,...,A5 in order.
//    active high for exactly 513 cycles.
// 2. Write 0x4015, then read (cpu_wr=0) at 0x4014 -> active stays 0, no mem_wr pulses.
// 3. Retrigger: write 0x07 to 0x4014 during byte 40 -> ignored.
//    Transfer finishes from page 0x02 with 256 writes total.
// 4. Assert rst during WRITE of byte 100 -> next cycle: active=0, mem_wr=0, no more writes.
//    A fresh trigger then restarts at idx 0.
// 5. Trigger on the first IDLE cycle after completion with page 0x03 -> second transfer starts.
//    Second transfer reads 0x0300-0x03FF.
// 6. Page 0x07 (0x0700-0x07FF): last source address 0x07FF, written as byte 255 -> idx does not wrap early.

Source files
------------

// File: rtl/sprdma.sv
// ---------------------------------------------------------------------------
// sprdma - sprite (OAM) DMA engine
//
// Purpose:
//   A CPU write to TRIGGER_ADDR starts a transfer that copies one CPU page
//   {page,8'h00}..{page,XFER_LEN-1} to the PPU OAM data port (DST_ADDR).
//   Each byte is moved in two bus cycles: READ puts the source address on
//   the bus, and WRITE forwards the returned read data to DST_ADDR. While
//   o_active is high, this block owns the memory bus and the CPU is halted.
//
// Handshake:
//   There is no valid/ready pair. A trigger is a single-cycle qualifier:
//   i_cpu_wr=1 with i_cpu_addr==TRIGGER_ADDR at a rising edge while IDLE.
//   The downstream side never back-pressures. i_mem_rd_data is valid one
//   cycle after its address was driven, so it is consumed in the WRITE cycle
//   that follows each READ.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous, active-high reset
//   i_cpu_addr     snooped CPU address
//   i_cpu_wr       CPU write strobe
//   i_cpu_din      CPU write data (page number on trigger)
//   i_mem_rd_data  memory read data (1-cycle synchronous latency)
//   o_mem_addr     bus address while active (0 when idle)
//   o_mem_wr       bus write enable (WRITE state only)
//   o_mem_wr_data  bus write data (0 outside WRITE)
//   o_active       1 = DMA owns the bus
//   o_dbg_state    current FSM state (0 IDLE, 1 START, 2 READ, 3 WRITE)
// ---------------------------------------------------------------------------
module sprdma #(
   parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] DST_ADDR     = 16'h2004,
   parameter int          XFER_LEN     = 256
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [15:0] i_cpu_addr,
   input  logic        i_cpu_wr,
   input  logic [7:0]  i_cpu_din,
   input  logic [7:0]  i_mem_rd_data,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_wr,
   output logic [7:0]  o_mem_wr_data,
   output logic        o_active,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_READ  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_page;
   logic [7:0] r_idx;
   logic       w_trigger;
   logic       w_last;

   assign w_trigger = i_cpu_wr && (i_cpu_addr == TRIGGER_ADDR);
   assign w_last    = (r_idx == LAST_IDX);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Page / byte index. The page is captured only on an accepted trigger,
   // so a retrigger mid-transfer cannot change the source page.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_page <= 8'd0;
         r_idx  <= 8'd0;
      end else if (r_state == S_IDLE && w_trigger) begin
         r_page <= i_cpu_din;
         r_idx  <= 8'd0;
      end else if (r_state == S_WRITE && !w_last) begin
         r_idx  <= r_idx + 8'd1;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_trigger) w_next_state = S_START;
         S_START: w_next_state = S_READ;
         S_READ:  w_next_state = S_WRITE;
         S_WRITE: w_next_state = w_last ? S_IDLE : S_READ;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output logic (purely a function of state, plus the read-data forward)
   always_comb begin
      o_active      = 1'b0;
      o_mem_wr      = 1'b0;
      o_mem_addr    = 16'h0000;
      o_mem_wr_data = 8'h00;
      case (r_state)
         S_START: begin
            o_active = 1'b1;
         end
         S_READ: begin
            o_active   = 1'b1;
            o_mem_addr = {r_page, r_idx};
         end
         S_WRITE: begin
            o_active      = 1'b1;
            o_mem_wr      = 1'b1;
            o_mem_addr    = DST_ADDR;
            o_mem_wr_data = i_mem_rd_data;
         end
         default: ;
      endcase
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sprdma.sv
// ---------------------------------------------------------------------------
// tb_sprdma - directed + randomized bench for the sprite DMA engine.
// A byte-wide RAM model with 1-cycle read latency answers the DMA's reads.
// Expected OAM write data is built per transfer from the RAM page contents
// (the reference model: a transfer of page P writes ram[{P,i}] for i=0..255).
// ---------------------------------------------------------------------------
module tb_sprdma;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_addr;
   logic        cpu_wr;
   logic [7:0]  cpu_din;
   logic [7:0]  mem_rd_data;
   logic [15:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_wr_data;
   logic        active;
   logic [1:0]  dbg_state;

   sprdma dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_cpu_addr    (cpu_addr),
      .i_cpu_wr      (cpu_wr),
      .i_cpu_din     (cpu_din),
      .i_mem_rd_data (mem_rd_data),
      .o_mem_addr    (mem_addr),
      .o_mem_wr      (mem_wr),
      .o_mem_wr_data (mem_wr_data),
      .o_active      (active),
      .o_dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- memory model ----------------
   logic [7:0]  ram [0:65535];
   logic [15:0] last_rd;

   always @(posedge clk) begin
      mem_rd_data <= ram[mem_addr];
      // source reads are the active, non-write cycles with a nonzero address
      if (active === 1'b1 && mem_wr === 1'b0 && mem_addr != 16'h0000)
         last_rd <= mem_addr;
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int act_cnt = 0;
   int wr_cnt  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor samples at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (active === 1'b1) act_cnt++;
      if (mem_wr === 1'b1) begin
         wr_cnt++;
         chk("wr_addr", {16'h0, mem_addr}, 32'h2004);
         if (exp_q.size() == 0) begin
            chk("unexpected_wr", 32'd1, 32'd0);
         end else begin
            chk("wr_data", {24'h0, mem_wr_data}, {24'h0, exp_q.pop_front()});
         end
      end else if (dbg_state !== 2'bxx) begin
         chk("idle_wr_data_zero", {24'h0, mem_wr_data}, 32'h0);
         if (active === 1'b0) chk("idle_addr_zero", {16'h0, mem_addr}, 32'h0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
      @(posedge clk); #1;
      cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_din = 8'h00;
   endtask

   task automatic cpu_read(input logic [15:0] a);
      cpu_addr = a; cpu_din = 8'h02; cpu_wr = 1'b0;
      @(posedge clk); #1;
      cpu_addr = 16'h0000; cpu_din = 8'h00;
   endtask

   task automatic push_page(input logic [7:0] p, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(ram[{p, 8'(i)}]);
   endtask

   task automatic clear_counts();
      act_cnt = 0; wr_cnt = 0;
   endtask

   // Returns at posedge+1 of the first IDLE cycle.
   task automatic wait_idle(input string tag);
      int k;
      for (k = 0; k < 2000; k++) begin
         if (active === 1'b0) break;
         @(posedge clk); #1;
      end
      if (k == 2000) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic wait_wr(input int n, input string tag);
      int k;
      for (k = 0; k < 2000; k++) begin
         if (wr_cnt >= n) break;
         @(posedge clk); #1;
      end
      if (k == 2000) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic full_xfer(input logic [7:0] p, input string tag);
      clear_counts();
      push_page(p, 256);
      cpu_write(16'h4014, p);
      chk({tag, "_start_active"}, {31'h0, active}, 32'd1);
      chk({tag, "_start_addr"}, {16'h0, mem_addr}, 32'h0);
      wait_idle(tag);
      chk({tag, "_active_cycles"}, act_cnt, 32'd513);
      chk({tag, "_wr_count"}, wr_cnt, 32'd256);
      chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
      chk({tag, "_last_src"}, {16'h0, last_rd}, {16'h0, p, 8'hFF});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] pg;
      rst = 1'b1; cpu_addr = 16'h0; cpu_wr = 1'b0; cpu_din = 8'h0;
      for (int i = 0; i < 256; i++) begin
         ram[{8'h02, 8'(i)}] = 8'(i) ^ 8'h5A;
         ram[{8'h03, 8'(i)}] = 8'($urandom);
         ram[{8'h07, 8'(i)}] = 8'($urandom);
      end
      cycle(3);
      chk("rst_active", {31'h0, active}, 32'd0);
      chk("rst_mem_wr", {31'h0, mem_wr}, 32'd0);
      chk("rst_mem_addr", {16'h0, mem_addr}, 32'd0);
      chk("rst_wr_data", {24'h0, mem_wr_data}, 32'd0);
      chk("rst_state", {30'h0, dbg_state}, 32'd0);
      rst = 1'b0;
      cycle(2);

      // 1: page 2 holds i^5A
      chk("t1_pattern_first", {24'h0, ram[16'h0200]}, 32'h5A);
      full_xfer(8'h02, "t1");

      // 2: non-triggering accesses
      clear_counts();
      cpu_write(16'h4015, 8'h02);
      cpu_read(16'h4014);
      cycle(10);
      chk("t2_no_active", act_cnt, 32'd0);
      chk("t2_no_wr", wr_cnt, 32'd0);

      // 3: retrigger during byte 40 is ignored
      clear_counts();
      push_page(8'h02, 256);
      cpu_write(16'h4014, 8'h02);
      wait_wr(40, "t3_wait");
      cpu_write(16'h4014, 8'h07);
      wait_idle("t3");
      chk("t3_active_cycles", act_cnt, 32'd513);
      chk("t3_wr_count", wr_cnt, 32'd256);
      chk("t3_last_src", {16'h0, last_rd}, 32'h02FF);

      // 4: reset during WRITE of byte 100
      clear_counts();
      push_page(8'h03, 101);
      cpu_write(16'h4014, 8'h03);
      wait_wr(100, "t4_wait");
      for (int k = 0; k < 10 && mem_wr !== 1'b1; k++) cycle(1);
      chk("t4_in_write", {31'h0, mem_wr}, 32'd1);
      rst = 1'b1;
      cycle(1);
      chk("t4_rst_active", {31'h0, active}, 32'd0);
      chk("t4_rst_wr", {31'h0, mem_wr}, 32'd0);
      rst = 1'b0;
      cycle(20);
      chk("t4_wr_count", wr_cnt, 32'd101);
      chk("t4_q_empty", exp_q.size(), 32'd0);

      // 4/6: fresh trigger restarts at idx 0; page 7 ends at 0x07FF
      full_xfer(8'h07, "t6");

      // 5: back-to-back trigger in first IDLE cycle
      full_xfer(8'h03, "t5");

      // randomized pages and contents with random idle gaps
      for (int n = 0; n < 3; n++) begin
         pg = 8'($urandom_range(8'h08, 8'h1F));
         for (int i = 0; i < 256; i++) ram[{pg, 8'(i)}] = 8'($urandom);
         cycle($urandom_range(0, 5));
         full_xfer(pg, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
